uart_axi_slave: RTL and testbench

AXI4 slave front end for the on-board direct-serial UART, sitting between the core's `io_uart_*` AXI master port and the byte-level UART transmit/receive engines. It decodes a data register and a status register, and buffers received bytes in an RX FIFO. It holds one pending TX byte and applies write backpressure while that byte is waiting. Address decode above bit 2 is done upstream, so every access that reaches this block targets the UART.

---
 rtl/uart_axi_slave.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_axi_slave.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axi_slave.sv
// uart_axi_slave
//   AXI4 slave front end for the direct-serial UART. Decodes two registers by
//   addr[2]: DATA (0) and STATUS (1). Received bytes are buffered in an RX FIFO.
//   One pending TX byte is held, with write backpressure while it is waiting.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   io_uart_ar_* / io_uart_r_* AXI4 read address / read data channels
//   io_uart_aw_* / io_uart_w_* AXI4 write address / write data channels
//   io_uart_b_*                AXI4 write response channel (resp always OKAY)
//   tx_start, tx_data          launch pulse and byte for the transmit engine
//   tx_busy                    transmit engine busy
//   rx_valid, rx_data          received-byte strobe and byte from the receive engine
module uart_axi_slave #(
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_uart_ar_id,
  input  logic [31:0] io_uart_ar_addr,
  input  logic [7:0]  io_uart_ar_len,
  input  logic [2:0]  io_uart_ar_size,
  input  logic [1:0]  io_uart_ar_burst,
  input  logic        io_uart_ar_valid,
  output logic        io_uart_ar_ready,
  output logic [7:0]  io_uart_r_id,
  output logic [31:0] io_uart_r_data,
  output logic [1:0]  io_uart_r_resp,
  output logic        io_uart_r_last,
  output logic        io_uart_r_valid,
  input  logic        io_uart_r_ready,
  input  logic [7:0]  io_uart_aw_id,
  input  logic [31:0] io_uart_aw_addr,
  input  logic [7:0]  io_uart_aw_len,
  input  logic [2:0]  io_uart_aw_size,
  input  logic [1:0]  io_uart_aw_burst,
  input  logic        io_uart_aw_valid,
  output logic        io_uart_aw_ready,
  input  logic [31:0] io_uart_w_data,
  input  logic [3:0]  io_uart_w_strb,
  input  logic        io_uart_w_last,
  input  logic        io_uart_w_valid,
  output logic        io_uart_w_ready,
  output logic [7:0]  io_uart_b_id,
  output logic [1:0]  io_uart_b_resp,
  output logic        io_uart_b_valid,
  input  logic        io_uart_b_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);
  localparam int AW = $clog2(RX_DEPTH);

  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  // read side
  rstate_t     r_rstate;
  logic        r_ar_ready, r_r_valid, r_r_last, r_rsel, r_beat_fifo;
  logic [7:0]  r_r_id, r_rcnt;
  logic [31:0] r_r_data;
  // write side
  wstate_t     r_wstate;
  logic        r_aw_ready, r_wsel, r_b_valid, r_tx_pend;
  logic [7:0]  r_b_id, r_tx_hold;
  // RX FIFO
  logic [7:0]  r_mem [RX_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        r_overrun;

  logic        w_ar_hs, w_r_hs, w_pop, w_push, w_drop, w_full, w_stat_clr;
  logic [AW:0] w_rd_ptr_next;
  logic        w_head_avail, w_tx_ready, w_beat_sel, w_beat_fifo;
  logic [7:0]  w_head;
  logic [31:0] w_beat_data;
  logic        w_w_ready, w_w_hs, w_tx_load, w_tx_launch;

  assign w_ar_hs    = io_uart_ar_valid & r_ar_ready;
  assign w_r_hs     = r_r_valid & io_uart_r_ready;
  // Pop only when the beat being consumed actually carried a FIFO byte.
  assign w_pop      = w_r_hs & r_beat_fifo;
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push     = rx_valid & (~w_full | w_pop);
  assign w_drop     = rx_valid & w_full & ~w_pop;
  assign w_stat_clr = w_r_hs & r_rsel;

  // Next beat is computed against the FIFO state after this cycle's pop,
  // so consecutive DATA beats walk through the FIFO.
  assign w_rd_ptr_next = r_rd_ptr + (AW+1)'(w_pop);
  assign w_head_avail  = (w_rd_ptr_next != r_wr_ptr);
  assign w_head        = r_mem[w_rd_ptr_next[AW-1:0]];
  assign w_tx_ready    = ~tx_busy & ~r_tx_pend;
  assign w_beat_sel    = (r_rstate == R_IDLE) ? io_uart_ar_addr[2] : r_rsel;
  assign w_beat_fifo   = ~w_beat_sel & w_head_avail;
  assign w_beat_data   = w_beat_sel
                       ? {29'b0, r_overrun & ~w_stat_clr, w_head_avail, w_tx_ready}
                       : (w_head_avail ? {24'b0, w_head} : 32'b0);

  assign w_w_ready   = (r_wstate == W_DATA) & (~r_tx_pend | r_wsel);
  assign w_w_hs      = io_uart_w_valid & w_w_ready;
  assign w_tx_load   = w_w_hs & ~r_wsel & io_uart_w_strb[0];
  assign w_tx_launch = r_tx_pend & ~tx_busy;

  // Read FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate    <= R_IDLE;
      r_ar_ready  <= 1'b0;
      r_r_valid   <= 1'b0;
      r_r_last    <= 1'b0;
      r_rsel      <= 1'b0;
      r_beat_fifo <= 1'b0;
      r_r_id      <= 8'b0;
      r_rcnt      <= 8'b0;
      r_r_data    <= 32'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_ar_ready <= 1'b1;
          if (w_ar_hs) begin
            r_ar_ready  <= 1'b0;
            r_r_id      <= io_uart_ar_id;
            r_rsel      <= io_uart_ar_addr[2];
            r_rcnt      <= io_uart_ar_len;
            r_r_valid   <= 1'b1;
            r_r_last    <= (io_uart_ar_len == 8'd0);
            r_r_data    <= w_beat_data;
            r_beat_fifo <= w_beat_fifo;
            r_rstate    <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rcnt == 8'd0) begin
              r_r_valid   <= 1'b0;
              r_r_last    <= 1'b0;
              r_beat_fifo <= 1'b0;
              r_ar_ready  <= 1'b1;
              r_rstate    <= R_IDLE;
            end else begin
              r_rcnt      <= r_rcnt - 8'd1;
              r_r_last    <= (r_rcnt == 8'd1);
              r_r_data    <= w_beat_data;
              r_beat_fifo <= w_beat_fifo;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Write FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate   <= W_IDLE;
      r_aw_ready <= 1'b0;
      r_wsel     <= 1'b0;
      r_b_valid  <= 1'b0;
      r_b_id     <= 8'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_aw_ready <= 1'b1;
          if (io_uart_aw_valid & r_aw_ready) begin
            r_aw_ready <= 1'b0;
            r_b_id     <= io_uart_aw_id;
            r_wsel     <= io_uart_aw_addr[2];
            r_wstate   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs & io_uart_w_last) begin
            r_b_valid <= 1'b1;
            r_wstate  <= W_RESP;
          end
        end
        W_RESP: begin
          if (io_uart_b_ready) begin
            r_b_valid  <= 1'b0;
            r_aw_ready <= 1'b1;
            r_wstate   <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // TX holding register; load and launch never coincide because w_ready
  // for DATA writes is held low while a byte is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_pend <= 1'b0;
      r_tx_hold <= 8'b0;
    end else if (w_tx_load) begin
      r_tx_pend <= 1'b1;
      r_tx_hold <= io_uart_w_data[7:0];
    end else if (w_tx_launch) begin
      r_tx_pend <= 1'b0;
    end
  end

  // RX FIFO storage (no reset needed: pointers define validity)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_ptr_next;
      if (w_drop)          r_overrun <= 1'b1;
      else if (w_stat_clr) r_overrun <= 1'b0;
    end
  end

  assign io_uart_ar_ready = r_ar_ready;
  assign io_uart_r_id     = r_r_id;
  assign io_uart_r_data   = r_r_data;
  assign io_uart_r_resp   = 2'b00;
  assign io_uart_r_last   = r_r_last;
  assign io_uart_r_valid  = r_r_valid;
  assign io_uart_aw_ready = r_aw_ready;
  assign io_uart_w_ready  = w_w_ready;
  assign io_uart_b_id     = r_b_id;
  assign io_uart_b_resp   = 2'b00;
  assign io_uart_b_valid  = r_b_valid;
  assign tx_start         = w_tx_launch;
  assign tx_data          = r_tx_hold;

  logic w_unused;
  assign w_unused = &{1'b0, io_uart_ar_addr[31:3], io_uart_ar_addr[1:0], io_uart_ar_size,
                      io_uart_ar_burst, io_uart_aw_addr[31:3], io_uart_aw_addr[1:0],
                      io_uart_aw_len, io_uart_aw_size, io_uart_aw_burst,
                      io_uart_w_data[31:8], io_uart_w_strb[3:1]};
endmodule

// File: tb/tb_uart_axi_slave.sv
// tb_uart_axi_slave
//   Self-checking bench for uart_axi_slave: a table of single-beat register
//   accesses and RX pushes, followed by hand-written multi-cycle sequences
//   (burst ordering, TX backpressure, overrun, full push+pop, concurrency,
//   mid-burst reset).
module tb_uart_axi_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ar_id, ar_len, r_id, aw_id, aw_len, b_id, tx_data, rx_data;
  logic [31:0] ar_addr, r_data, aw_addr, w_data;
  logic [2:0]  ar_size, aw_size;
  logic [1:0]  ar_burst, aw_burst, r_resp, b_resp;
  logic [3:0]  w_strb;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        tx_start, tx_busy, rx_valid;

  always #5 clk = ~clk;

  uart_axi_slave #(.RX_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .io_uart_ar_id(ar_id), .io_uart_ar_addr(ar_addr), .io_uart_ar_len(ar_len),
    .io_uart_ar_size(ar_size), .io_uart_ar_burst(ar_burst),
    .io_uart_ar_valid(ar_valid), .io_uart_ar_ready(ar_ready),
    .io_uart_r_id(r_id), .io_uart_r_data(r_data), .io_uart_r_resp(r_resp),
    .io_uart_r_last(r_last), .io_uart_r_valid(r_valid), .io_uart_r_ready(r_ready),
    .io_uart_aw_id(aw_id), .io_uart_aw_addr(aw_addr), .io_uart_aw_len(aw_len),
    .io_uart_aw_size(aw_size), .io_uart_aw_burst(aw_burst),
    .io_uart_aw_valid(aw_valid), .io_uart_aw_ready(aw_ready),
    .io_uart_w_data(w_data), .io_uart_w_strb(w_strb), .io_uart_w_last(w_last),
    .io_uart_w_valid(w_valid), .io_uart_w_ready(w_ready),
    .io_uart_b_id(b_id), .io_uart_b_resp(b_resp), .io_uart_b_valid(b_valid),
    .io_uart_b_ready(b_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .rx_valid(rx_valid), .rx_data(rx_data)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          tx_cnt  = 0;
  logic [7:0]  tx_last = 8'h00;
  logic [31:0] rd_beats [0:31];
  logic [31:0] rd_lasts;

  // count launch pulses and remember the launched byte
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      tx_cnt  = tx_cnt + 1;
      tx_last = tx_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tmo(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Burst read; optionally raise rx_valid in the cycle of beat push_beat.
  task automatic do_read(input logic a2, input logic [7:0] len,
                         input int push_beat, input logic [7:0] push_byte);
    bit ok;
    @(posedge clk); #1;
    ar_valid = 1'b1;
    ar_addr  = {29'b0, a2, 2'b00};
    ar_len   = len;
    ar_id    = 8'h3C;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ar_ready) begin ok = 1; break; end
    end
    if (!ok) begin tmo("ar"); ar_valid = 1'b0; return; end
    @(posedge clk); #1;
    ar_valid = 1'b0;
    r_ready  = 1'b1;
    rd_lasts = 32'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == push_beat) begin rx_valid = 1'b1; rx_data = push_byte; end
      ok = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (r_valid) begin ok = 1; break; end
      end
      if (!ok) begin tmo("r"); r_ready = 1'b0; rx_valid = 1'b0; return; end
      rd_beats[b] = r_data;
      rd_lasts[b] = r_last;
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
    r_ready = 1'b0;
  endtask

  task automatic wr_aw(input logic a2);
    bit ok;
    @(posedge clk); #1;
    aw_valid = 1'b1;
    aw_addr  = {29'b0, a2, 2'b00};
    aw_id    = 8'hA5;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (aw_ready) begin ok = 1; break; end
    end
    if (!ok) begin tmo("aw"); aw_valid = 1'b0; return; end
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic wr_w(input logic [31:0] d, input logic [3:0] s);
    bit ok;
    w_valid = 1'b1;
    w_data  = d;
    w_strb  = s;
    w_last  = 1'b1;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (w_ready) begin ok = 1; break; end
    end
    if (!ok) begin tmo("w"); w_valid = 1'b0; return; end
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic wr_b();
    bit ok;
    b_ready = 1'b1;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (b_valid) begin ok = 1; break; end
    end
    if (!ok) begin tmo("b"); b_ready = 1'b0; return; end
    chk("b_resp", {30'b0, b_resp}, 32'h0);
    chk("b_id", {24'b0, b_id}, 32'hA5);
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  task automatic do_write(input logic a2, input logic [31:0] d, input logic [3:0] s);
    wr_aw(a2);
    wr_w(d, s);
    wr_b();
  endtask

  // kind: 0 push d[7:0]; 1 single read of a2, expect exp; 2 write d/strb, exp = launches
  typedef struct {
    int          kind;
    logic        a2;
    logic [31:0] d;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    bit seen;
    tbl[0]  = '{1, 1'b1, 32'h0,   4'h0, 32'h1,  "status after reset"};
    tbl[1]  = '{1, 1'b0, 32'h0,   4'h0, 32'h0,  "data empty"};
    tbl[2]  = '{0, 1'b0, 32'h5A,  4'h0, 32'h0,  "push 5A"};
    tbl[3]  = '{0, 1'b0, 32'hC3,  4'h0, 32'h0,  "push C3"};
    tbl[4]  = '{1, 1'b1, 32'h0,   4'h0, 32'h3,  "status rx_avail"};
    tbl[5]  = '{1, 1'b0, 32'h0,   4'h0, 32'h5A, "data 5A"};
    tbl[6]  = '{1, 1'b0, 32'h0,   4'h0, 32'hC3, "data C3"};
    tbl[7]  = '{1, 1'b1, 32'h0,   4'h0, 32'h1,  "status drained"};
    tbl[8]  = '{2, 1'b1, 32'h41,  4'hF, 32'h0,  "write status ignored"};
    tbl[9]  = '{2, 1'b0, 32'h41,  4'h1, 32'h1,  "write data 41"};
    tbl[10] = '{2, 1'b0, 32'h99,  4'hE, 32'h0,  "write data strb0 low"};
    tbl[11] = '{2, 1'b0, 32'h1FF, 4'h1, 32'h1,  "write data FF"};

    rst = 1'b1;
    ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 3'd2; ar_burst = 2'd1; ar_valid = 0;
    r_ready = 0;
    aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 3'd2; aw_burst = 2'd1; aw_valid = 0;
    w_data = 0; w_strb = 0; w_last = 0; w_valid = 0; b_ready = 0;
    tx_busy = 0; rx_valid = 0; rx_data = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctl outputs", {25'b0, ar_ready, aw_ready, r_valid, r_last, w_ready, b_valid, tx_start}, 32'h0);
    chk("reset r_data", r_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready after reset", {30'b0, ar_ready, aw_ready}, 32'h3);

    // table-driven part
    for (int i = 0; i < 12; i++) begin
      case (tbl[i].kind)
        0: push(tbl[i].d[7:0]);
        1: begin
          do_read(tbl[i].a2, 8'd0, -1, 8'h00);
          chk(tbl[i].name, rd_beats[0], tbl[i].exp);
          chk({tbl[i].name, " last"}, {31'b0, rd_lasts[0]}, 32'h1);
        end
        default: begin
          c0 = tx_cnt;
          do_write(tbl[i].a2, tbl[i].d, tbl[i].strb);
          chk({tbl[i].name, " launches"}, tx_cnt - c0, tbl[i].exp);
          if (tbl[i].exp != 0)
            chk({tbl[i].name, " tx_data"}, {24'b0, tx_last}, {24'b0, tbl[i].d[7:0]});
        end
      endcase
    end

    // RX ordering with a burst that runs past the FIFO contents
    push(8'h10); push(8'h20); push(8'h30);
    do_read(1'b0, 8'd3, -1, 8'h00);
    chk("burst beat0", rd_beats[0], 32'h10);
    chk("burst beat1", rd_beats[1], 32'h20);
    chk("burst beat2", rd_beats[2], 32'h30);
    chk("burst beat3", rd_beats[3], 32'h0);
    chk("burst r_last", rd_lasts, 32'h8);
    do_read(1'b1, 8'd0, -1, 8'h00);
    chk("status after burst", rd_beats[0], 32'h1);

    // TX backpressure: 0x42 waits behind tx_busy, a following write is held off
    @(posedge clk); #1;
    tx_busy = 1'b1;
    c0 = tx_cnt;
    do_write(1'b0, 32'h42, 4'h1);
    chk("no launch while busy", tx_cnt - c0, 32'h0);
    do_read(1'b1, 8'd0, -1, 8'h00);
    chk("status tx not ready", rd_beats[0], 32'h0);
    wr_aw(1'b0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (w_ready) seen = 1;
    end
    chk("w_ready held low", {31'b0, seen}, 32'h0);
    @(posedge clk); #1;
    tx_busy = 1'b0;
    @(negedge clk);
    chk("tx_start on busy fall", {31'b0, tx_start}, 32'h1);
    chk("tx_data 42", {24'b0, tx_data}, 32'h42);
    wr_w(32'h43, 4'h1);
    wr_b();
    chk("launches 42 and 43", tx_cnt - c0, 32'h2);
    chk("tx_data 43", {24'b0, tx_last}, 32'h43);

    // overrun: one byte more than the FIFO holds
    for (int i = 0; i < 17; i++) push(8'hA0 + 8'(i));
    do_read(1'b1, 8'd0, -1, 8'h00);
    chk("status overrun", rd_beats[0], 32'h7);
    do_read(1'b1, 8'd0, -1, 8'h00);
    chk("status overrun cleared", rd_beats[0], 32'h3);
    do_read(1'b0, 8'd15, -1, 8'h00);
    for (int i = 0; i < 16; i++) chk($sformatf("ovr beat%0d", i), rd_beats[i], 32'hA0 + 32'(i));
    chk("ovr burst r_last", rd_lasts, 32'h8000);
    do_read(1'b0, 8'd0, -1, 8'h00);
    chk("extra byte lost", rd_beats[0], 32'h0);

    // full FIFO with push coinciding with a pop
    for (int i = 0; i < 16; i++) push(8'hB0 + 8'(i));
    do_read(1'b0, 8'd15, 0, 8'hEE);
    chk("full beat0", rd_beats[0], 32'hB0);
    chk("full beat15", rd_beats[15], 32'hBF);
    do_read(1'b1, 8'd0, -1, 8'h00);
    chk("status no overrun", rd_beats[0], 32'h3);
    do_read(1'b0, 8'd0, -1, 8'h00);
    chk("new byte last out", rd_beats[0], 32'hEE);
    do_read(1'b1, 8'd0, -1, 8'h00);
    chk("status empty", rd_beats[0], 32'h1);

    // concurrency: read parked in R_DATA while a write completes
    push(8'h77);
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_addr = 32'h0; ar_len = 8'd0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ar_ready) begin seen = 1; break; end
    end
    if (!seen) tmo("ar parked");
    @(posedge clk); #1;
    ar_valid = 1'b0;
    c0 = tx_cnt;
    do_write(1'b0, 32'h55, 4'h1);
    chk("concurrent launch", tx_cnt - c0, 32'h1);
    chk("concurrent tx_data", {24'b0, tx_last}, 32'h55);
    @(negedge clk);
    chk("parked r_valid", {31'b0, r_valid}, 32'h1);
    chk("parked r_data", r_data, 32'h77);
    @(posedge clk); #1;
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
    do_read(1'b1, 8'd0, -1, 8'h00);
    chk("status after parked read", rd_beats[0], 32'h1);

    // reset in the middle of a burst
    push(8'h01); push(8'h02); push(8'h03);
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_addr = 32'h0; ar_len = 8'd3;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ar_ready) begin seen = 1; break; end
    end
    if (!seen) tmo("ar midreset");
    @(posedge clk); #1;
    ar_valid = 1'b0;
    r_ready  = 1'b1;
    @(negedge clk);
    chk("midreset beat0", r_data, 32'h01);
    @(posedge clk); #1;
    rst     = 1'b1;
    r_ready = 1'b0;
    @(negedge clk);
    chk("midreset ctl outputs", {25'b0, ar_ready, aw_ready, r_valid, r_last, w_ready, b_valid, tx_start}, 32'h0);
    chk("midreset r_data", r_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_read(1'b1, 8'd0, -1, 8'h00);
    chk("status after midreset", rd_beats[0], 32'h1);
    do_read(1'b0, 8'd0, -1, 8'h00);
    chk("fifo flushed", rd_beats[0], 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
